// File: rtl/add_tree_acc.sv
// Registered binary adder tree summing NUM_IN elements per beat, followed by a
// block accumulator that reports one total (with overflow flag) every ACC_LEN valid beats.
module add_tree_acc #(
  parameter int unsigned BIT_WIDTH = 14,
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned ACC_LEN   = 16,
  parameter int unsigned OUT_WIDTH = BIT_WIDTH + $clog2(NUM_IN) + $clog2(ACC_LEN),
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [NUM_IN*BIT_WIDTH-1:0] elements,
  output logic                        out_valid,
  output logic [OUT_WIDTH-1:0]        sum_out,
  output logic                        sat_flag
);

  localparam int unsigned LV = $clog2(NUM_IN);
  localparam int unsigned TW = BIT_WIDTH + LV;
  localparam int unsigned SW = ((OUT_WIDTH > TW) ? OUT_WIDTH : TW) + 1;
  localparam int unsigned CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  // Level k holds NUM_IN>>k partial sums, each one bit wider than level k-1.
  for (genvar k = 1; k <= LV; k++) begin : lv
    localparam int unsigned N = NUM_IN >> k;
    localparam int unsigned W = BIT_WIDTH + k;

    logic [W-2:0] a [2*N];
    logic [W-1:0] s [N];
    logic         v;

    if (k == 1) begin : src
      for (genvar j = 0; j < 2*N; j++) begin : el
        assign a[j] = elements[j*BIT_WIDTH +: BIT_WIDTH];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) v <= 1'b0;
        else     v <= in_valid & ~clear;
      end
    end else begin : src
      for (genvar j = 0; j < 2*N; j++) begin : el
        assign a[j] = lv[k-1].s[j];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) v <= 1'b0;
        else     v <= lv[k-1].v & ~clear;
      end
    end

    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N; i++) begin
        s[i] <= {1'b0, a[2*i]} + {1'b0, a[2*i+1]};
      end
    end
  end

  logic [TW-1:0] tree;
  logic          tree_v;

  assign tree   = lv[LV].s[0];
  assign tree_v = lv[LV].v;

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_nxt;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic                 ovf_now;
  logic                 ovf_nxt;
  logic                 last;
  logic [SW-1:0]        total;

  // Sum is formed wide enough to hold both operands plus carry, so a tree
  // result wider than OUT_WIDTH is caught by the same overflow test.
  always_comb begin
    total   = SW'(acc) + SW'(tree);
    ovf_now = |total[SW-1:OUT_WIDTH];
    ovf_nxt = ovf | ovf_now;
    acc_nxt = (SATURATE && ovf_nxt) ? '1 : total[OUT_WIDTH-1:0];
    last    = (cnt == CW'(ACC_LEN - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      sum_out   <= '0;
      sat_flag  <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tree_v) begin
        if (last) begin
          sum_out   <= acc_nxt;
          sat_flag  <= ovf_nxt;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          ovf <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_tree_acc.sv
// Bench for add_tree_acc: three instances (default width, 18-bit saturating,
// 18-bit wrapping) share stimulus and are checked against a block-sum model.
module tb_add_tree_acc;
  localparam int BW = 14;
  localparam int NI = 4;
  localparam int AL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [NI*BW-1:0] elements = '0;

  logic        ov0, ov1, ov2;
  logic [19:0] so0;
  logic [17:0] so1, so2;
  logic        sf0, sf1, sf2;

  always #5 clk = ~clk;

  add_tree_acc #(.BIT_WIDTH(BW), .NUM_IN(NI), .ACC_LEN(AL)) d0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .elements(elements),
    .out_valid(ov0), .sum_out(so0), .sat_flag(sf0));

  add_tree_acc #(.BIT_WIDTH(BW), .NUM_IN(NI), .ACC_LEN(AL), .OUT_WIDTH(18), .SATURATE(1'b1)) d1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .elements(elements),
    .out_valid(ov1), .sum_out(so1), .sat_flag(sf1));

  add_tree_acc #(.BIT_WIDTH(BW), .NUM_IN(NI), .ACC_LEN(AL), .OUT_WIDTH(18), .SATURATE(1'b0)) d2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .elements(elements),
    .out_valid(ov2), .sum_out(so2), .sat_flag(sf2));

  typedef struct packed {
    int               due;
    logic [2:0][19:0] s;
    logic [2:0]       f;
  } exp_t;

  int     checks = 0;
  int     failures = 0;
  int     edge_n = 0;
  exp_t   eq[$];
  longint macc[3];
  bit     movf[3];
  int     mcnt;
  longint last_s[3];
  bit     last_f[3];
  int     ow[3]  = '{20, 18, 18};
  bit     sat[3] = '{1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NI*BW-1:0] pk(input int a, input int b, input int c, input int d);
    return {14'(d), 14'(c), 14'(b), 14'(a)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      macc[i] = 0;
      movf[i] = 1'b0;
    end
    mcnt = 0;
  endtask

  // One accepted beat: add the element sum into each block total at the
  // instance's width, clamping or wrapping on carry-out.
  task automatic model_beat(input logic [NI*BW-1:0] el);
    longint tree = 0;
    for (int n = 0; n < NI; n++) tree += longint'(el[n*BW +: BW]);
    mcnt++;
    for (int i = 0; i < 3; i++) begin
      longint mx = (longint'(1) << ow[i]) - 1;
      longint t  = macc[i] + tree;
      if (t > mx) begin
        movf[i] = 1'b1;
        macc[i] = sat[i] ? mx : (t & mx);
      end else begin
        macc[i] = t;
      end
    end
    if (mcnt == AL) begin
      exp_t e = '0;
      e.due = edge_n + 2;
      for (int i = 0; i < 3; i++) begin
        e.s[i] = 20'(macc[i]);
        e.f[i] = movf[i];
      end
      eq.push_back(e);
      model_reset();
    end
  endtask

  task automatic check_outputs();
    logic [2:0]  v  = {ov2, ov1, ov0};
    logic [2:0]  f  = {sf2, sf1, sf0};
    logic [63:0] s[3];
    bit          due = (eq.size() > 0) && (eq[0].due == edge_n);
    exp_t        e = '0;
    s[0] = 64'(so0);
    s[1] = 64'(so1);
    s[2] = 64'(so2);
    if (due) e = eq.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid[%0d]@%0d", i, edge_n), 64'(v[i]), 64'(due));
      if (due) begin
        chk($sformatf("sum_out[%0d]@%0d", i, edge_n), s[i], 64'(e.s[i]));
        chk($sformatf("sat_flag[%0d]@%0d", i, edge_n), 64'(f[i]), 64'(e.f[i]));
        last_s[i] = longint'(e.s[i]);
        last_f[i] = e.f[i];
      end else begin
        chk($sformatf("sum_hold[%0d]@%0d", i, edge_n), s[i], 64'(last_s[i]));
        chk($sformatf("flag_hold[%0d]@%0d", i, edge_n), 64'(f[i]), 64'(last_f[i]));
      end
    end
  endtask

  task automatic cycle(input bit v, input bit clr, input logic [NI*BW-1:0] el);
    in_valid = v;
    clear    = clr;
    elements = el;
    @(posedge clk);
    edge_n++;
    if (clr) begin
      while (eq.size() > 0 && eq[eq.size()-1].due >= edge_n) void'(eq.pop_back());
      model_reset();
    end else if (v) begin
      model_beat(el);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    eq.delete();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      last_s[i] = 0;
      last_f[i] = 1'b0;
    end
    #1;
    chk("rst_out_valid", 64'({ov2, ov1, ov0}), 64'(0));
    chk("rst_sum_out", 64'({so2, so1, so0}), 64'(0));
    chk("rst_sat_flag", 64'({sf2, sf1, sf0}), 64'(0));
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // block of ones
    for (int i = 0; i < AL; i++) cycle(1'b1, 1'b0, pk(1, 1, 1, 1));
    idle(4);

    // two back-to-back full-scale blocks, then a block of ones
    for (int i = 0; i < 2*AL; i++) cycle(1'b1, 1'b0, pk(16383, 16383, 16383, 16383));
    for (int i = 0; i < AL; i++) cycle(1'b1, 1'b0, pk(1, 1, 1, 1));
    idle(4);

    // valid every other cycle
    for (int i = 0; i < 2*AL; i++) cycle(i % 2 == 0, 1'b0, pk(1, 2, 3, 4));
    idle(4);

    // clear mid-block (with a beat offered alongside), then a block of twos
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, pk(1, 1, 1, 1));
    idle(3);
    cycle(1'b1, 1'b1, pk(5, 5, 5, 5));
    for (int i = 0; i < AL; i++) cycle(1'b1, 1'b0, pk(2, 2, 2, 2));
    idle(4);

    // clear arrives exactly when the last beat reaches the accumulator
    for (int i = 0; i < AL; i++) cycle(1'b1, 1'b0, pk(7, 7, 7, 7));
    idle(1);
    cycle(1'b0, 1'b1, '0);
    idle(3);
    for (int i = 0; i < AL; i++) cycle(1'b1, 1'b0, pk(3, 3, 3, 3));
    idle(4);

    // reset mid-block, then a block of twos
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, pk(1, 1, 1, 1));
    do_reset();
    for (int i = 0; i < AL; i++) cycle(1'b1, 1'b0, pk(2, 2, 2, 2));
    idle(4);

    // random traffic with gaps and occasional clear
    for (int i = 0; i < 400; i++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      bit clr = ($urandom_range(0, 59) == 0);
      logic [NI*BW-1:0] el = {14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom)};
      if ($urandom_range(0, 1) == 0) el = el & {NI{14'h00ff}};
      cycle(v, clr, el);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_tree_acc.md
# add_tree_acc

Pipelined, parametrised multi-operand adder with block accumulation for the motion-estimation datapath. Each valid beat, it sums NUM_IN unsigned elements through a registered binary adder tree. It then accumulates ACC_LEN such beats into one block total, for example a SAD over a block row set. It replaces chains of two-input combinational adders where operand count and clock rate make a single-cycle sum infeasible.

## Interface
- BIT_WIDTH, 14, width of each unsigned input element
- NUM_IN, 4, elements per beat; power of two, ≥ 2
- ACC_LEN, 16, beats per block total; ≥ 1
- OUT_WIDTH, BIT_WIDTH+clog2(NUM_IN)+clog2(ACC_LEN), width of block total
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^OUT_WIDTH
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- clear  input  1  synchronous flush of pipeline, accumulator and beat count
- in_valid  input  1  elements valid this cycle
- elements  input  NUM_IN*BIT_WIDTH  packed operands; element i at [i*BIT_WIDTH +: BIT_WIDTH]
- out_valid  output  1  one-cycle pulse; sum_out/sat_flag carry a completed block
- sum_out  output  OUT_WIDTH  block total
- sat_flag  output  1  an overflow occurred within the reported block

## Operation
- Tree: LV = clog2(NUM_IN) registered levels.
  - Level k adds adjacent pairs from level k−1 and widens by 1 bit.
  - Tree result width is TW = BIT_WIDTH+LV.
  - A valid bit travels with each level; invalid beats propagate as bubbles and never touch the accumulator.
- Accumulator: registers acc (OUT_WIDTH bits) and cnt (0..ACC_LEN−1).
  - On a valid tree output with cnt < ACC_LEN−1: acc ← acc+tree, cnt ← cnt+1.
  - On a valid tree output with cnt = ACC_LEN−1: compute total = acc+tree, then set sum_out ← total, out_valid ← 1, acc ← 0, cnt ← 0.
  - ACC_LEN=1: every valid beat produces a total.
- Overflow: computed at OUT_WIDTH+1 bits; carry-out = overflow.
  - SATURATE=1: acc clamps to 2^OUT_WIDTH−1 and stays clamped for the rest of the block.
  - SATURATE=0: acc keeps the low OUT_WIDTH bits.
  - Either mode: a sticky ovf bit is set and reported as sat_flag with the block's out_valid, then cleared.
  - If TW > OUT_WIDTH, the tree result alone can exceed range; it is treated identically.
- clear:
  - Zeroes all level valid bits, acc, cnt and ovf on the next edge.
  - in_valid asserted in the same cycle as clear is discarded.
  - sum_out retains its last value; out_valid is 0 the cycle after clear.
- Gaps in in_valid are unrestricted; there is no backpressure and the block always accepts.

## Timing
- Reset values: out_valid=0, sum_out=0, sat_flag=0; internal acc=0, cnt=0, ovf=0, all valid bits=0.
- Latency from the beat that completes a block (ACC_LEN-th valid beat) to out_valid high: LV+1 cycles. Defaults: 3.
- Throughput: one beat per cycle; back-to-back blocks give out_valid every ACC_LEN cycles with no dead cycle.
- out_valid is high for exactly 1 cycle per block.
- sum_out and sat_flag are stable from out_valid until the next out_valid.
- Reset mid-block: the partial block is lost and no out_valid is produced for it.
- Clear in the same cycle the tree delivers the last beat of a block: clear wins and no out_valid is produced.

## Test plan
- Defaults. All elements = 1, in_valid high for 16 cycles → single out_valid 3 cycles after the 16th beat, sum_out = 64, sat_flag = 0.
- Defaults. All elements = 16383 for 32 consecutive beats → two out_valid pulses exactly 16 cycles apart, each with sum_out = 1048512 and sat_flag = 0.
- OUT_WIDTH=18, SATURATE=1. All elements = 16383 for 16 beats → sum_out = 262143, sat_flag = 1; the next block of all 1s gives 64 with sat_flag = 0.
- OUT_WIDTH=18, SATURATE=0. Same stimulus → sum_out = 1048512 mod 262144 = 262080, sat_flag = 1.
- Defaults. Element values 1,2,3,4 with in_valid toggled every other cycle over 32 cycles (16 beats) → sum_out = 160, out_valid 3 cycles after the last valid beat.
- Defaults. Assert clear after 10 beats of 1s, then feed 16 beats of 2s → no out_valid for the first 10 beats; one out_valid with sum_out = 128. Repeat with rst instead of clear: same result, and outputs read 0 until the first block completes.
